// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef logic       Signal;
  typedef logic [4:0] RegAddr;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } HazState;

  // Load in X writes a register that the D instruction reads; $0 is never a hazard.
  function automatic Signal f_load_use(Signal is_load, RegAddr rd,
                                       Signal uses_rs, RegAddr rs,
                                       Signal uses_rt, RegAddr rt);
    return is_load && (rd != '0) &&
           ((uses_rs && (rs == rd)) || (uses_rt && (rt == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(parameter int PERF_W = 32);
  import hazard_ctrl_pkg::*;

  RegAddr              d_rs_a;
  RegAddr              d_rt_a;
  Signal               d_uses_rs;
  Signal               d_uses_rt;
  Signal               x_is_load;
  RegAddr              x_rd_a;
  Signal               x_jmp;
  Signal               x_muldiv;
  Signal               mem_wait;

  Signal               pc_stall;
  Signal               fd_stall;
  Signal               fd_bubble;
  Signal               dx_stall;
  Signal               dx_bubble;
  Signal               xm_stall;
  Signal               xm_bubble;
  Signal               muldiv_busy;
  logic [PERF_W-1:0]   stall_cycles;

  // Pipeline side: reports stage status, obeys stall/bubble controls.
  modport master (
    output d_rs_a, d_rt_a, d_uses_rs, d_uses_rt, x_is_load, x_rd_a,
           x_jmp, x_muldiv, mem_wait,
    input  pc_stall, fd_stall, fd_bubble, dx_stall, dx_bubble,
           xm_stall, xm_bubble, muldiv_busy, stall_cycles
  );

  // Controller side.
  modport slave (
    input  d_rs_a, d_rt_a, d_uses_rs, d_uses_rt, x_is_load, x_rd_a,
           x_jmp, x_muldiv, mem_wait,
    output pc_stall, fd_stall, fd_bubble, dx_stall, dx_bubble,
           xm_stall, xm_bubble, muldiv_busy, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: prioritised stall/bubble generation for FD/DX/XM and PC,
// mul/div occupancy FSM and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  HazState           r_state;
  logic [CNT_W-1:0]  r_busy_cnt;
  logic [PERF_W-1:0] r_stall_cycles;

  HazState           w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  Signal             w_load_use;
  Signal             w_pc_stall, w_fd_stall, w_fd_bubble;
  Signal             w_dx_stall, w_dx_bubble, w_xm_stall, w_xm_bubble;

  assign w_load_use = f_load_use(hz.x_is_load, hz.x_rd_a,
                                 hz.d_uses_rs, hz.d_rs_a,
                                 hz.d_uses_rt, hz.d_rt_a);

  // State, busy countdown and perf counter; reset drops straight back to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_busy_cnt     <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (w_pc_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  // Next-state and outputs: one priority rule wins per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_busy_cnt;
    w_pc_stall  = 1'b0;
    w_fd_stall  = 1'b0;
    w_fd_bubble = 1'b0;
    w_dx_stall  = 1'b0;
    w_dx_bubble = 1'b0;
    w_xm_stall  = 1'b0;
    w_xm_bubble = 1'b0;
    if (rst) begin
      w_fd_bubble = 1'b1;
      w_dx_bubble = 1'b1;
      w_xm_bubble = 1'b1;
    end else if (hz.mem_wait) begin
      // Freeze everything, including the mul/div countdown.
      w_pc_stall = 1'b1;
      w_fd_stall = 1'b1;
      w_dx_stall = 1'b1;
      w_xm_stall = 1'b1;
    end else if ((r_state == BUSY) || hz.x_muldiv) begin
      // X is occupied: hold the front end, feed a bubble into M.
      w_pc_stall  = 1'b1;
      w_fd_stall  = 1'b1;
      w_dx_stall  = 1'b1;
      w_xm_bubble = 1'b1;
      if (r_state == RUN) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_W'(MULDIV_LAT - 2);
      end else if (r_busy_cnt == '0) begin
        w_state_nxt = RUN;
      end else begin
        w_cnt_nxt = r_busy_cnt - CNT_W'(1);
      end
    end else if (hz.x_jmp) begin
      // Flush wrong-path D and X; PC is free to load the target.
      w_fd_bubble = 1'b1;
      w_dx_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall  = 1'b1;
      w_fd_stall  = 1'b1;
      w_dx_bubble = 1'b1;
    end
  end

  assign hz.pc_stall     = w_pc_stall;
  assign hz.fd_stall     = w_fd_stall;
  assign hz.fd_bubble    = w_fd_bubble;
  assign hz.dx_stall     = w_dx_stall;
  assign hz.dx_bubble    = w_dx_bubble;
  assign hz.xm_stall     = w_xm_stall;
  assign hz.xm_bubble    = w_xm_bubble;
  assign hz.muldiv_busy  = !rst && (r_state == BUSY);
  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (LAT=4, 32-bit counter) and a
// small instance (LAT=2, 2-bit counter) for the minimum-latency and saturation corners.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(32)) hz  ();
  hazard_ctrl_if #(.PERF_W(2))  hz2 ();

  hazard_ctrl #(.MULDIV_LAT(4), .PERF_W(32)) dut  (.clk(clk), .rst(rst), .hz(hz));
  hazard_ctrl #(.MULDIV_LAT(2), .PERF_W(2))  dut2 (.clk(clk), .rst(rst), .hz(hz2));

  // {pc_stall, fd_stall, fd_bubble, dx_stall, dx_bubble, xm_stall, xm_bubble, muldiv_busy}
  logic [7:0] w_o, w_o2;
  assign w_o  = {hz.pc_stall, hz.fd_stall, hz.fd_bubble, hz.dx_stall,
                 hz.dx_bubble, hz.xm_stall, hz.xm_bubble, hz.muldiv_busy};
  assign w_o2 = {hz2.pc_stall, hz2.fd_stall, hz2.fd_bubble, hz2.dx_stall,
                 hz2.dx_bubble, hz2.xm_stall, hz2.xm_bubble, hz2.muldiv_busy};

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_RST  = 8'b0010_1010;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_JMP  = 8'b0010_1000;
  localparam logic [7:0] O_MD0  = 8'b1101_0010;
  localparam logic [7:0] O_MDB  = 8'b1101_0011;
  localparam logic [6:0] O_MW   = 7'b1101_010;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic ld, input logic [4:0] rd,
                     input logic urs, input logic [4:0] rs,
                     input logic urt, input logic [4:0] rt,
                     input logic jmp, input logic md, input logic mw);
    hz.x_is_load = ld;  hz.x_rd_a = rd;
    hz.d_uses_rs = urs; hz.d_rs_a = rs;
    hz.d_uses_rt = urt; hz.d_rt_a = rt;
    hz.x_jmp = jmp; hz.x_muldiv = md; hz.mem_wait = mw;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to the next negedge, leaving #1 for combinational outputs to settle.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    idle();
    hz2.d_rs_a = '0; hz2.d_rt_a = '0; hz2.d_uses_rs = 1'b0; hz2.d_uses_rt = 1'b0;
    hz2.x_is_load = 1'b0; hz2.x_rd_a = '0; hz2.x_jmp = 1'b0;
    hz2.x_muldiv = 1'b0; hz2.mem_wait = 1'b0;

    // Reset: bubbles only, counter clear.
    nxt(); #1;
    chk("rst_outs", w_o, O_RST);
    chk("rst_cnt", hz.stall_cycles, 0);
    nxt(); rst = 1'b0; #1;
    chk("idle_outs", w_o, O_IDLE);

    // 1: load-use on rs.
    nxt(); drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_rs", w_o, O_LU);
    nxt(); idle(); #1;
    chk("lu_after", w_o, O_IDLE);
    chk("lu_cnt", hz.stall_cycles, 1);
    // load-use on rt
    nxt(); drv(1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_rt", w_o, O_LU);
    // match but operand not read: no hazard
    nxt(); drv(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_unused", w_o, O_IDLE);
    // match but not a load
    nxt(); drv(1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_noload", w_o, O_IDLE);

    // 2: $0 never hazards.
    nxt(); drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_r0", w_o, O_IDLE);
    chk("lu_r0_cnt", hz.stall_cycles, 2);

    // 3: branch beats load-use, no stall counted.
    nxt(); drv(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
    chk("jmp_lu", w_o, O_JMP);
    nxt(); idle(); #1;
    chk("jmp_cnt", hz.stall_cycles, 2);

    // 4: mul/div pulse, 4 stall cycles; x_jmp ignored while BUSY.
    nxt(); drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
    chk("md_start", w_o, O_MD0);
    nxt(); idle(); #1;
    chk("md_b1", w_o, O_MDB);
    nxt(); hz.x_jmp = 1'b1; #1;
    chk("md_b2_jmp", w_o, O_MDB);
    nxt(); idle(); #1;
    chk("md_b3", w_o, O_MDB);
    nxt(); #1;
    chk("md_done", w_o, O_IDLE);
    chk("md_cnt", hz.stall_cycles, 6);

    // 5: mem_wait x3 inside BUSY stretches the stall to 7 cycles.
    nxt(); hz.x_muldiv = 1'b1; #1;
    chk("mw_start", w_o, O_MD0);
    nxt(); idle(); #1;
    chk("mw_b1", w_o, O_MDB);
    for (int i = 0; i < 3; i++) begin
      nxt(); hz.mem_wait = 1'b1; #1;
      chk($sformatf("mw_hold%0d", i), w_o[7:1], O_MW);
    end
    nxt(); idle(); #1;
    chk("mw_b2", w_o, O_MDB);
    nxt(); #1;
    chk("mw_b3", w_o, O_MDB);
    nxt(); #1;
    chk("mw_done", w_o, O_IDLE);
    chk("mw_cnt", hz.stall_cycles, 13);

    // 6: reset in the 2nd BUSY cycle.
    nxt(); hz.x_muldiv = 1'b1; #1;
    chk("rb_start", w_o, O_MD0);
    nxt(); idle(); #1;
    chk("rb_b1", w_o, O_MDB);
    nxt(); rst = 1'b1; #1;
    chk("rb_rst_outs", w_o, O_RST);
    chk("rb_rst_cnt", hz.stall_cycles, 0);
    nxt(); rst = 1'b0; #1;
    chk("rb_after", w_o, O_IDLE);
    nxt(); #1;
    chk("rb_after2", w_o, O_IDLE);
    chk("rb_cnt", hz.stall_cycles, 0);

    // Minimum latency (LAT=2) on the small instance.
    nxt(); hz2.x_muldiv = 1'b1; #1;
    chk("l2_start", w_o2, O_MD0);
    nxt(); hz2.x_muldiv = 1'b0; #1;
    chk("l2_b1", w_o2, O_MDB);
    nxt(); #1;
    chk("l2_done", w_o2, O_IDLE);
    chk("l2_cnt", hz2.stall_cycles, 2);

    // Counter saturation at 2^2-1.
    for (int i = 0; i < 5; i++) begin
      nxt(); hz2.mem_wait = 1'b1; #1;
      chk($sformatf("sat_stall%0d", i), hz2.pc_stall, 1);
    end
    nxt(); hz2.mem_wait = 1'b0; #1;
    chk("sat_cnt", hz2.stall_cycles, 3);
    chk("main_untouched", hz.stall_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
